// File: rtl/mario_pkg.sv
// Shared definitions for Mario's motion engine, sprite renderer and software header generation.
package mario_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned X_LSB   = 0;
    localparam int unsigned Y_LSB   = 16;

    localparam int unsigned DEF_X_MIN    = 0;
    localparam int unsigned DEF_X_MAX    = 620;
    localparam int unsigned DEF_X_START  = 32;
    localparam int unsigned DEF_X_STEP   = 2;
    localparam int unsigned DEF_Y_MIN    = 0;
    localparam int unsigned DEF_GROUND_Y = 400;
    localparam int unsigned DEF_JUMP_VEL = 12;
    localparam int unsigned DEF_GRAVITY  = 1;
    localparam int unsigned DEF_MAX_FALL = 12;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } motion_state_e;

    // Position word as seen by the PIO in_port and the renderer: {y, x}.
    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } pos_t;

endpackage

// File: rtl/mario_vert_fsm.sv
// Vertical motion: jump/rise/fall state, vertical speed, y coordinate and jump re-arm latch.
module mario_vert_fsm
    import mario_pkg::*;
#(
    parameter int unsigned Y_MIN    = DEF_Y_MIN,
    parameter int unsigned GROUND_Y = DEF_GROUND_Y,
    parameter int unsigned JUMP_VEL = DEF_JUMP_VEL,
    parameter int unsigned GRAVITY  = DEF_GRAVITY,
    parameter int unsigned MAX_FALL = DEF_MAX_FALL
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick_i,
    input  logic               key_jump_i,
    output logic [COORD_W-1:0] y_o,
    output motion_state_e      state_o
);

    localparam int unsigned VY_W = 8;

    motion_state_e      state_q, state_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [VY_W-1:0]    vy_q, vy_d;
    logic               armed_q, armed_d;

    logic [VY_W:0]      vy_inc;
    logic [VY_W-1:0]    vy_fall;
    logic [VY_W-1:0]    vy_dec;
    logic [COORD_W:0]   y_fall;
    logic               rise_hits_top;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_GROUND;
            y_q     <= COORD_W'(GROUND_Y);
            vy_q    <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            armed_q <= armed_d;
        end
    end

    // Rise overshoot and landing are detected one bit wider so nothing wraps.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vy_d    = vy_q;
        armed_d = armed_q;

        vy_inc        = (VY_W+1)'(vy_q) + (VY_W+1)'(GRAVITY);
        vy_fall       = (vy_inc >= (VY_W+1)'(MAX_FALL)) ? VY_W'(MAX_FALL) : vy_inc[VY_W-1:0];
        vy_dec        = (vy_q > VY_W'(GRAVITY)) ? vy_q - VY_W'(GRAVITY) : '0;
        y_fall        = (COORD_W+1)'(y_q) + (COORD_W+1)'(vy_fall);
        rise_hits_top = (COORD_W+1)'(y_q) < ((COORD_W+1)'(vy_q) + (COORD_W+1)'(Y_MIN));

        if (tick_i) begin
            if (!key_jump_i) begin
                armed_d = 1'b1;
            end
            case (state_q)
                ST_RISE: begin
                    if (vy_q == '0) begin
                        state_d = ST_FALL;
                    end else if (rise_hits_top) begin
                        y_d     = COORD_W'(Y_MIN);
                        vy_d    = '0;
                        state_d = ST_FALL;
                    end else begin
                        y_d  = y_q - COORD_W'(vy_q);
                        vy_d = vy_dec;
                    end
                end
                ST_FALL: begin
                    if (y_fall >= (COORD_W+1)'(GROUND_Y)) begin
                        y_d     = COORD_W'(GROUND_Y);
                        vy_d    = '0;
                        state_d = ST_GROUND;
                    end else begin
                        y_d  = y_fall[COORD_W-1:0];
                        vy_d = vy_fall;
                    end
                end
                default: begin
                    // Covers GROUND and the unused encoding.
                    state_d = ST_GROUND;
                    y_d     = COORD_W'(GROUND_Y);
                    vy_d    = '0;
                    if (key_jump_i && armed_q) begin
                        y_d     = COORD_W'(GROUND_Y) - COORD_W'(JUMP_VEL);
                        vy_d    = VY_W'(JUMP_VEL) - VY_W'(GRAVITY);
                        state_d = ST_RISE;
                        armed_d = 1'b0;
                    end
                end
            endcase
        end
    end

    assign y_o     = y_q;
    assign state_o = state_q;

endmodule

// File: rtl/mario_motion_engine.sv
// Per-frame Mario position update: horizontal walk with clamping plus the vertical jump FSM.
module mario_motion_engine
    import mario_pkg::*;
#(
    parameter int unsigned X_MIN    = DEF_X_MIN,
    parameter int unsigned X_MAX    = DEF_X_MAX,
    parameter int unsigned X_START  = DEF_X_START,
    parameter int unsigned X_STEP   = DEF_X_STEP,
    parameter int unsigned Y_MIN    = DEF_Y_MIN,
    parameter int unsigned GROUND_Y = DEF_GROUND_Y,
    parameter int unsigned JUMP_VEL = DEF_JUMP_VEL,
    parameter int unsigned GRAVITY  = DEF_GRAVITY,
    parameter int unsigned MAX_FALL = DEF_MAX_FALL
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_jump,
    output logic [31:0] position,
    output logic [1:0]  motion_state,
    output logic        frame_done
);

    logic [COORD_W-1:0] x_q, x_d;
    logic               frame_done_q, frame_done_d;
    logic [COORD_W:0]   x_ext;
    logic [COORD_W-1:0] y_w;
    motion_state_e      state_w;
    pos_t               pos_w;

    mario_vert_fsm #(
        .Y_MIN    (Y_MIN),
        .GROUND_Y (GROUND_Y),
        .JUMP_VEL (JUMP_VEL),
        .GRAVITY  (GRAVITY),
        .MAX_FALL (MAX_FALL)
    ) u_vert (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_i     (frame_tick),
        .key_jump_i (key_jump),
        .y_o        (y_w),
        .state_o    (state_w)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q          <= COORD_W'(X_START);
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Horizontal step, clamped in 17 bits so the edges never wrap.
    always_comb begin
        x_d          = x_q;
        frame_done_d = frame_tick;
        x_ext        = (COORD_W+1)'(x_q);
        if (frame_tick) begin
            case ({key_left, key_right})
                2'b10: begin
                    if (x_ext < ((COORD_W+1)'(X_MIN) + (COORD_W+1)'(X_STEP))) begin
                        x_d = COORD_W'(X_MIN);
                    end else begin
                        x_d = x_q - COORD_W'(X_STEP);
                    end
                end
                2'b01: begin
                    if ((x_ext + (COORD_W+1)'(X_STEP)) > (COORD_W+1)'(X_MAX)) begin
                        x_d = COORD_W'(X_MAX);
                    end else begin
                        x_d = x_q + COORD_W'(X_STEP);
                    end
                end
                default: x_d = x_q;
            endcase
        end
    end

    assign pos_w.x      = x_q;
    assign pos_w.y      = y_w;
    assign position     = pos_w;
    assign motion_state = state_w;
    assign frame_done   = frame_done_q;

endmodule
